// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Two writeback sources (A = ALU, B = load) each own a one-entry holding
// buffer. One buffered write is issued per cycle through a registered output
// stage. Writes to the same register always leave in acceptance order. A
// pending-write mask is exported for hazard detection.
module regfile_write_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     ReqA_Valid,
    input  logic [ADDR_W-1:0]        ReqA_Reg,
    input  logic [DATA_W-1:0]        ReqA_Data,
    output logic                     ReqA_Ready,
    input  logic                     ReqB_Valid,
    input  logic [ADDR_W-1:0]        ReqB_Reg,
    input  logic [DATA_W-1:0]        ReqB_Data,
    output logic                     ReqB_Ready,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteRegister,
    output logic [DATA_W-1:0]        WriteData,
    output logic [(1<<ADDR_W)-1:0]   PendingMask
);

    localparam int NREG = 1 << ADDR_W;

    // Holding buffers
    logic              a_vld_q, a_vld_d;
    logic [ADDR_W-1:0] a_reg_q, a_reg_d;
    logic [DATA_W-1:0] a_dat_q, a_dat_d;
    logic              b_vld_q, b_vld_d;
    logic [ADDR_W-1:0] b_reg_q, b_reg_d;
    logic [DATA_W-1:0] b_dat_q, b_dat_d;

    // Arbitration state: prio_b = B preferred next, older_b = B holds the older entry
    logic              prio_b_q, prio_b_d;
    logic              older_b_q, older_b_d;

    // Output stage
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_dat_q, wr_dat_d;

    logic              gnt_a_s, gnt_b_s;
    logic              acc_a_s, acc_b_s;
    logic [ADDR_W-1:0] gnt_reg_s;
    logic [DATA_W-1:0] gnt_dat_s;
    logic [NREG-1:0]   pend_s;

    // Grant decision from buffer state only; same-register conflicts go to the older entry
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (a_vld_q && b_vld_q) begin
            if (a_reg_q == b_reg_q) begin
                gnt_b_s = older_b_q;
            end else begin
                gnt_b_s = prio_b_q;
            end
            gnt_a_s = ~gnt_b_s;
        end else begin
            gnt_a_s = a_vld_q;
            gnt_b_s = b_vld_q;
        end
    end

    assign gnt_reg_s  = gnt_b_s ? b_reg_q : a_reg_q;
    assign gnt_dat_s  = gnt_b_s ? b_dat_q : a_dat_q;

    // A buffer can be refilled in the same cycle it drains; nothing is accepted in reset
    assign ReqA_Ready = Rst_n & (~a_vld_q | gnt_a_s);
    assign ReqB_Ready = Rst_n & (~b_vld_q | gnt_b_s);
    assign acc_a_s    = ReqA_Valid & ReqA_Ready;
    assign acc_b_s    = ReqB_Valid & ReqB_Ready;

    // Next-state: buffer fill/drain, round-robin pointer, buffer age, output stage
    always_comb begin
        a_vld_d   = a_vld_q;
        a_reg_d   = a_reg_q;
        a_dat_d   = a_dat_q;
        b_vld_d   = b_vld_q;
        b_reg_d   = b_reg_q;
        b_dat_d   = b_dat_q;
        prio_b_d  = prio_b_q;
        older_b_d = older_b_q;
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_dat_d  = wr_dat_q;

        if (acc_a_s) begin
            a_vld_d = 1'b1;
            a_reg_d = ReqA_Reg;
            a_dat_d = ReqA_Data;
        end else if (gnt_a_s) begin
            a_vld_d = 1'b0;
        end else begin
            a_vld_d = a_vld_q;
        end

        if (acc_b_s) begin
            b_vld_d = 1'b1;
            b_reg_d = ReqB_Reg;
            b_dat_d = ReqB_Data;
        end else if (gnt_b_s) begin
            b_vld_d = 1'b0;
        end else begin
            b_vld_d = b_vld_q;
        end

        if (gnt_a_s) begin
            prio_b_d = 1'b1;
        end else if (gnt_b_s) begin
            prio_b_d = 1'b0;
        end else begin
            prio_b_d = prio_b_q;
        end

        // A fresh entry is younger than any surviving one; simultaneous accepts make A older
        if (acc_a_s && acc_b_s) begin
            older_b_d = 1'b0;
        end else if (acc_a_s && b_vld_q && !gnt_b_s) begin
            older_b_d = 1'b1;
        end else if (acc_b_s && a_vld_q && !gnt_a_s) begin
            older_b_d = 1'b0;
        end else begin
            older_b_d = older_b_q;
        end

        if (gnt_a_s || gnt_b_s) begin
            wr_reg_d = gnt_reg_s;
            wr_dat_d = gnt_dat_s;
            wr_en_d  = ~(DROP_R0 && (gnt_reg_s == {ADDR_W{1'b0}}));
        end else begin
            wr_en_d  = 1'b0;
        end
    end

    // Pending-write scoreboard: both buffers plus the write currently on the port
    always_comb begin
        pend_s = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            pend_s[i] = (a_vld_q && (a_reg_q == ADDR_W'(i))) ||
                        (b_vld_q && (b_reg_q == ADDR_W'(i))) ||
                        (wr_en_q && (wr_reg_q == ADDR_W'(i)));
        end
        pend_s[0] = pend_s[0] & ~DROP_R0;
    end

    assign PendingMask   = pend_s;
    assign RegWrite      = wr_en_q;
    assign WriteRegister = wr_reg_q;
    assign WriteData     = wr_dat_q;

    // State registers; reset discards any in-flight writes
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_vld_q   <= 1'b0;
            a_reg_q   <= {ADDR_W{1'b0}};
            a_dat_q   <= {DATA_W{1'b0}};
            b_vld_q   <= 1'b0;
            b_reg_q   <= {ADDR_W{1'b0}};
            b_dat_q   <= {DATA_W{1'b0}};
            prio_b_q  <= 1'b0;
            older_b_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= {ADDR_W{1'b0}};
            wr_dat_q  <= {DATA_W{1'b0}};
        end else begin
            a_vld_q   <= a_vld_d;
            a_reg_q   <= a_reg_d;
            a_dat_q   <= a_dat_d;
            b_vld_q   <= b_vld_d;
            b_reg_q   <= b_reg_d;
            b_dat_q   <= b_dat_d;
            prio_b_q  <= prio_b_d;
            older_b_q <= older_b_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_dat_q  <= wr_dat_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table,
// hand-written corner sequences and a randomized run against a slot/timestamp
// reference model plus a final register-file content comparison.
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic        ReqA_Valid, ReqB_Valid;
    logic [4:0]  ReqA_Reg, ReqB_Reg;
    logic [31:0] ReqA_Data, ReqB_Data;
    logic        ReqA_Ready, ReqB_Ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] PendingMask;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqA_Valid(ReqA_Valid), .ReqA_Reg(ReqA_Reg), .ReqA_Data(ReqA_Data), .ReqA_Ready(ReqA_Ready),
        .ReqB_Valid(ReqB_Valid), .ReqB_Reg(ReqB_Reg), .ReqB_Data(ReqB_Data), .ReqB_Ready(ReqB_Ready),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .PendingMask(PendingMask)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Two slots, each stamped with its acceptance time; the smaller stamp is older.
    logic        mv [2];
    logic [4:0]  mr [2];
    logic [31:0] md [2];
    int          mt [2];
    int          mprio;          // 0 = A preferred, 1 = B preferred
    int          cyc;
    logic        m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic [31:0] rf_exp [32];    // last accepted value per register
    logic [31:0] rf_dut [32];    // what the DUT actually wrote

    function automatic int mgrant();
        if (mv[0] && mv[1]) begin
            if (mr[0] == mr[1]) return (mt[0] < mt[1]) ? 0 : 1;
            return mprio;
        end
        if (mv[0]) return 0;
        if (mv[1]) return 1;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; mr[i] = 5'd0; md[i] = 32'd0; mt[i] = 0;
        end
        mprio = 0;
        m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
        for (int r = 0; r < 32; r++) begin
            rf_exp[r] = 32'd0;
            rf_dut[r] = 32'd0;
        end
    endtask

    // Called at a negedge: asserts reset, checks the immediate reset state, releases at next negedge.
    task automatic do_reset();
        Rst_n = 1'b0;
        ReqA_Valid = 1'b0; ReqA_Reg = 5'd0; ReqA_Data = 32'd0;
        ReqB_Valid = 1'b0; ReqB_Reg = 5'd0; ReqB_Data = 32'd0;
        #1;
        chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("rst_pending", {32'd0, PendingMask}, 64'd0);
        chk("rst_ready_a", {63'd0, ReqA_Ready}, 64'd0);
        chk("rst_ready_b", {63'd0, ReqB_Ready}, 64'd0);
        @(posedge Clk); #1;
        chk("rst_wreg", {59'd0, WriteRegister}, 64'd0);
        chk("rst_wdata", {32'd0, WriteData}, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
    endtask

    // One model-checked cycle: drive at negedge, check, advance model, move to next negedge.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd);
        int          g;
        logic        rdy [2];
        logic [31:0] em;
        logic        iv [2];
        logic [4:0]  ir [2];
        logic [31:0] id [2];
        ReqA_Valid = av; ReqA_Reg = ar; ReqA_Data = ad;
        ReqB_Valid = bv; ReqB_Reg = br; ReqB_Data = bd;
        #1;
        g = mgrant();
        rdy[0] = !mv[0] || (g == 0);
        rdy[1] = !mv[1] || (g == 1);
        em = 32'd0;
        for (int i = 0; i < 2; i++) if (mv[i]) em[mr[i]] = 1'b1;
        if (m_we) em[m_wr] = 1'b1;
        em[0] = 1'b0;
        chk("ready_a", {63'd0, ReqA_Ready}, {63'd0, rdy[0]});
        chk("ready_b", {63'd0, ReqB_Ready}, {63'd0, rdy[1]});
        chk("regwrite", {63'd0, RegWrite}, {63'd0, m_we});
        chk("wreg", {59'd0, WriteRegister}, {59'd0, m_wr});
        chk("wdata", {32'd0, WriteData}, {32'd0, m_wd});
        chk("pending", {32'd0, PendingMask}, {32'd0, em});
        chk("pending_r0", {63'd0, PendingMask[0]}, 64'd0);
        if (RegWrite) rf_dut[WriteRegister] = WriteData;
        // model edge: issue granted slot, then accept new requests (A before B)
        if (g >= 0) begin
            m_we  = (mr[g] != 5'd0);
            m_wr  = mr[g];
            m_wd  = md[g];
            mprio = 1 - g;
            mv[g] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        iv[0] = av; ir[0] = ar; id[0] = ad;
        iv[1] = bv; ir[1] = br; id[1] = bd;
        for (int i = 0; i < 2; i++) begin
            if (iv[i] && rdy[i]) begin
                mv[i] = 1'b1; mr[i] = ir[i]; md[i] = id[i]; mt[i] = 2 * cyc + i;
                if (ir[i] != 5'd0) rf_exp[ir[i]] = id[i];
            end
        end
        cyc++;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        av; logic [4:0] ar; logic [31:0] ad;
        logic        bv; logic [4:0] br; logic [31:0] bd;
        logic        ea; logic eb; logic ewe; logic [4:0] ewr; logic [31:0] ewd;
    } vec_t;

    vec_t tbl [14];

    initial begin
        cyc = 0;
        Rst_n = 1'b0;
        ReqA_Valid = 1'b0; ReqA_Reg = 5'd0; ReqA_Data = 32'd0;
        ReqB_Valid = 1'b0; ReqB_Reg = 5'd0; ReqB_Data = 32'd0;
        model_reset();

        // lone A stream r1..r4, then contention A:r2,r3 vs B:r6,r7
        tbl[0]  = '{1'b1, 1'b1, 5'd1, 32'hA1, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 5'd2, 32'hA2, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd1, 32'hA1};
        tbl[3]  = '{1'b0, 1'b1, 5'd4, 32'hA4, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd2, 32'hA2};
        tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3, 32'hA3};
        tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd4, 32'hA4};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd4, 32'hA4};
        tbl[7]  = '{1'b1, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd6, 32'hB6, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd7, 32'hB7, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'hB7, 1'b0, 1'b1, 1'b1, 5'd2, 32'hA2};
        tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd6, 32'hB6};
        tbl[11] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3, 32'hA3};
        tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd7, 32'hB7};
        tbl[13] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd7, 32'hB7};

        @(negedge Clk);
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            ReqA_Valid = tbl[i].av; ReqA_Reg = tbl[i].ar; ReqA_Data = tbl[i].ad;
            ReqB_Valid = tbl[i].bv; ReqB_Reg = tbl[i].br; ReqB_Data = tbl[i].bd;
            #1;
            chk($sformatf("tbl%0d_ready_a", i), {63'd0, ReqA_Ready}, {63'd0, tbl[i].ea});
            chk($sformatf("tbl%0d_ready_b", i), {63'd0, ReqB_Ready}, {63'd0, tbl[i].eb});
            chk($sformatf("tbl%0d_regwrite", i), {63'd0, RegWrite}, {63'd0, tbl[i].ewe});
            chk($sformatf("tbl%0d_wreg", i), {59'd0, WriteRegister}, {59'd0, tbl[i].ewr});
            chk($sformatf("tbl%0d_wdata", i), {32'd0, WriteData}, {32'd0, tbl[i].ewd});
            @(posedge Clk);
            @(negedge Clk);
        end

        // reset mid-traffic: bufA holds {r5,0x11} while r3 is on the port
        do_reset();
        step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        chk("mid_regwrite_before", {63'd0, RegWrite}, 64'd1);
        chk("mid_pend5_before", {63'd0, PendingMask[5]}, 64'd1);
        do_reset();
        idle(5);
        chk("mid_r5_never", {32'd0, rf_dut[5]}, 64'd0);

        // same register: B first, then A one edge later -> A's data final
        do_reset();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hBBBB);
        step(1'b1, 5'd9, 32'hAAAA, 1'b0, 5'd0, 32'd0);
        idle(3);
        chk("samereg_seq_r9", {32'd0, rf_dut[9]}, {32'd0, 32'hAAAA});

        // same register, same-cycle accept while B is preferred -> A older, issued first
        do_reset();
        step(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'd0);
        idle(1);
        step(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd9, 32'hBBBB);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("samecyc_first_data", {32'd0, WriteData}, {32'd0, 32'hAAAA});
        idle(3);
        chk("samecyc_r9", {32'd0, rf_dut[9]}, {32'd0, 32'hBBBB});

        // register 0 writes are consumed silently
        do_reset();
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        idle(3);
        chk("r0_never_written", {32'd0, rf_dut[0]}, 64'd0);

        // scoreboard lifetime of a B write to r12
        do_reset();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC);
        chk("sb_after_n", {63'd0, PendingMask[12]}, 64'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("sb_during_write", {63'd0, PendingMask[12]}, 64'd1);
        chk("sb_regwrite", {63'd0, RegWrite}, 64'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("sb_after_n2", {63'd0, PendingMask[12]}, 64'd0);

        // randomized traffic with frequent register collisions
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic        av, bv;
            logic [4:0]  ar, br;
            logic [31:0] ad, bd;
            av = ($urandom_range(0, 99) < 60);
            bv = ($urandom_range(0, 99) < 60);
            ar = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            br = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ad = $urandom;
            bd = $urandom;
            step(av, ar, ad, bv, br, bd);
        end
        idle(4);
        for (int r = 0; r < 32; r++) begin
            chk($sformatf("rf_final_r%0d", r), {32'd0, rf_dut[r]}, {32'd0, rf_exp[r]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
